// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with selectable read mode (registered read or
// first-word-fall-through), occupancy count, programmable almost-full/empty
// thresholds, overflow/underflow pulses and a synchronous flush (dump).
module fifo_param #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 9,
  parameter int unsigned FWFT   = 0,
  parameter int unsigned AF_LVL = 2**AW - 4,
  parameter int unsigned AE_LVL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH    = 2**AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LVL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic          pop_ok;
  logic          push_ok;

  // Accept decisions from pre-edge state; a full FIFO takes a push when a pop frees a slot
  always_comb begin
    pop_ok  = pop & (count != '0);
    push_ok = push & ((count != FULL_CNT) | pop_ok);
    rd_nxt  = rd_ptr + AW'(1);
  end

  // Status flags decode the registered count only
  always_comb begin
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
  end

  // Storage write; contents are deliberately not cleared by reset or flush
  always_ff @(posedge clk) begin
    if (!rst && !dump && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy count, with reset taking priority over flush
  always_ff @(posedge clk) begin
    if (rst || dump) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Rejected-request pulses, suppressed during a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push & ~push_ok & ~dump;
      underflow <= pop & ~pop_ok & ~dump;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head-word register: tracks the oldest entry, forwarding din when the
      // pushed word becomes the new head (empty, or single entry being popped)
      always_ff @(posedge clk) begin
        if (rst || dump) begin
          dout <= '0;
        end else if (pop_ok) begin
          if (count == (AW+1)'(1)) begin
            dout <= push_ok ? din : '0;
          end else begin
            dout <= mem[rd_nxt];
          end
        end else if (push_ok && count == '0) begin
          dout <= din;
        end
      end
    end else begin : g_reg
      // Registered read: load the head on an accepted pop, hold across flush
      always_ff @(posedge clk) begin
        if (rst) begin
          dout <= '0;
        end else if (!dump && pop_ok) begin
          dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the successor to the fixed 32x512 `fifo`. It adds configurable width and depth and a selectable read mode (registered read or first-word-fall-through). It also provides an occupancy count, programmable almost-full/almost-empty thresholds, sticky-free overflow/underflow pulses and a flush (`dump`). It sits between a producer and a consumer in a single clock domain and is a drop-in replacement for `fifo` when `FWFT=0` and the defaults are used.

## Interface
- `DW`, 32, data width in bits.
- `AW`, 9, address width; depth = 2**AW (512 by default).
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- `AF_LVL`, 2**AW-4, `almost_full` asserts when count >= AF_LVL (1..2**AW).
- `AE_LVL`, 4, `almost_empty` asserts when count <= AE_LVL (0..2**AW-1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `dump`  in  1  synchronous flush; discards all contents.
- `push`  in  1  write request.
- `din`  in  DW  write data, sampled with `push`.
- `pop`  in  1  read request.
- `dout`  out  DW  read data.
- `empty`  out  1  count == 0.
- `full`  out  1  count == 2**AW.
- `almost_full`  out  1  count >= AF_LVL.
- `almost_empty`  out  1  count <= AE_LVL.
- `count`  out  AW+1  current occupancy, 0..2**AW.
- `overflow`  out  1  one-cycle pulse: a push was rejected.
- `underflow`  out  1  one-cycle pulse: a pop was rejected.

## Operation
- Storage: 2**AW x DW array with AW-bit read and write pointers that wrap modulo 2**AW. `count` is held in a separate AW+1-bit register; it is not derived from the pointers.
- Accept rules, evaluated on the pre-edge state:
  - pop_ok = pop & (count != 0).
  - push_ok = push & ((count != 2**AW) | pop_ok). When full, a simultaneous push and pop are both accepted.
  - When empty, a simultaneous push and pop: the push is accepted and the pop is rejected (`underflow` pulses). There is no bypass in either mode.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Priority: `rst` > `dump` > push/pop.
- `dump`: pointers and count go to 0. Any same-cycle push/pop is ignored and flagged as neither overflow nor underflow. `dout` is unchanged when FWFT=0 and goes to 0 when FWFT=1.
- `overflow` = registered (push & !push_ok & !dump). `underflow` = registered (pop & !pop_ok & !dump).
- FWFT=0: on pop_ok, `dout` loads mem[rd_ptr] at the edge. Otherwise `dout` holds its value.
- FWFT=1: `dout` is a register that always holds the head word whenever count != 0. It is 0 when empty. A pop_ok advances it to the next word, or to the word being pushed in the same cycle when only one entry remains.
- Flags are decoded from the registered count. No status output has a combinational path from an input.

## Timing
- Reset, sampled at an edge with `rst`=1: pointers 0, count 0, `dout` 0, `empty` 1, `almost_empty` 1 (AE_LVL >= 0), `full` 0, `almost_full` 0, `overflow` 0, `underflow` 0. Memory contents are not cleared.
- Reset mid-operation behaves the same as a flush plus the `dout` clear, and takes effect at that edge.
- Write latency: a word pushed at edge N is poppable at edge N+1. `empty` deasserts after edge N.
- FWFT=0 read latency: pop at edge N leads to data on `dout` after edge N, valid for sampling at edge N+1.
- FWFT=1: the first word appears on `dout` after the edge at which it was written, in the same cycle `empty` falls.
- `full`, `almost_*`, `count`, `overflow` and `underflow` all change only after the edge that caused them (one-edge latency).
- Throughput: one push and one pop per cycle, sustained, at any occupancy.

## Test plan
- Reset then stream (FWFT=0): after 2 idle cycles plus a `rst` pulse, push 0x10 then 0x11, then pop twice. `dout` must read 0x10, then 0x11. `count` goes 0,1,2,1,0 and `empty` returns to 1.
- Fill to full (AW=4, AF_LVL=12, AE_LVL=4): push 0..15. `almost_empty` falls at count 5, `almost_full` rises at count 12, `full` rises at 16. A 17th push pulses `overflow` for one cycle and `count` stays 16.
- Full with simultaneous push+pop: push 0xAA while popping. The pop returns 0, `count` stays 16, `overflow`=0. After draining, the last word out is 0xAA.
- Empty underflow and empty push+pop: pop on empty pulses `underflow` and leaves `dout` unchanged. Push 0x5 with pop on empty: `underflow` pulses and `count` becomes 1.
- Wrap-around and FWFT=1: 3 x (push 16 words, pop 16) with incrementing data. Data must be in order with no loss across pointer wraps. `dout` shows the head word with no pop issued.
- Dump: with 7 entries held, assert `dump` together with `push`. Next cycle `count`=0, `empty`=1, no overflow. A following push of 0x77 then pop returns 0x77.
